trigger_capture: RTL and testbench
==================================

# trigger_capture

Trigger-side measurement block: receives an external, asynchronous trigger pulse train and measures it with a free-running-style cycle counter. The block is the receiving end of the trigger path produced by the team's counter-based trigger generators. When armed, it waits for a leading edge, measures active-pulse width and edge-to-edge period in clock cycles, then reports once with a one-cycle `done` strobe. Results are held until the next arm, so the top level can multiplex them onto output pins.

## Interface
- `CNT_WIDTH`, default 24: width of the measurement counter and the result registers.

- `clk`  input  1  system clock.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `trig_in`  input  1  external trigger; asynchronous to `clk`.
- `arm`  input  1  start request, sampled on `clk`; honoured only in IDLE.
- `edge_sel`  input  1  0 = active-high pulse (leading edge rising); 1 = active-low pulse (leading edge falling). Sampled at arm.
- `busy`  output  1  high while a measurement is in progress.
- `done`  output  1  one-cycle strobe when the results are valid.
- `width`  output  CNT_WIDTH  cycles the synchronized trigger spent at the active level.
- `period`  output  CNT_WIDTH  cycles from leading edge to the next leading edge.
- `overflow`  output  1  counter saturated before the measurement completed.

## Operation
- Synchronizer: `trig_in` passes through 2 flops (s1, s2), then a third flop s3 for edge detection.
  - Polarity is normalised by XOR with the latched `edge_sel`.
  - Leading edge = s2 active and s3 inactive.
  - Trailing edge = s2 inactive and s3 active.
- FSM states:
  - IDLE: `busy` = 0. On `arm` = 1, latch `edge_sel`, clear `width`, `period` and `overflow` to 0, go to WAIT_LEAD.
  - WAIT_LEAD: on a leading edge, set cnt to 1 and go to HIGH. If the level is already active at arm, a fresh leading edge is required.
  - HIGH: cnt increments each cycle. On a trailing edge, latch `width` = cnt, keep counting, and go to LOW.
  - LOW: cnt increments. On a leading edge, latch `period` = cnt and go to DONE.
  - DONE: `done` = 1 for exactly one cycle, then return to IDLE.
- Counter arithmetic:
  - cnt is unsigned CNT_WIDTH and saturates at 2^CNT_WIDTH−1; it never wraps.
  - If cnt is at all-ones in HIGH or LOW and the awaited edge has not arrived, set `overflow` = 1, force each not-yet-latched result to all-ones, and go to DONE.
  - A `width` already latched is kept.
- WAIT_LEAD has no timeout; it waits indefinitely.
- Arming rules:
  - `arm` outside IDLE is ignored, including in DONE.
  - `edge_sel` changes after arming are ignored until the next arm.
- Results and `overflow` hold their values from DONE until the next accepted `arm`.

## Timing
- Reset (asynchronous, active-low) sets the FSM to IDLE, clears s1–s3 and cnt, and sets `busy` = 0, `done` = 0, `width` = 0, `period` = 0, `overflow` = 0.
  - Reset mid-measurement aborts the measurement with no `done` pulse.
- `arm` sampled high at edge t: `busy` = 1 from edge t onward (registered); results read 0 after edge t.
- Edge latency: the FSM acts on an edge of `trig_in` at the second rising `clk` edge after the edge that first samples the new level.
- Result scaling: for a `trig_in` driven synchronously, high for N cycles then low for M cycles, `width` = N and `period` = N+M.
- Minimum resolvable active or inactive phase: 1 cycle.
- `done` and all results update on the same edge; `busy` falls on the edge on which `done` falls.
- Simultaneous leading edge and saturation in LOW: the edge wins (`period` = all-ones, `overflow` = 0).

## Test plan
- CNT_WIDTH = 24, `edge_sel` = 0; arm, then drive `trig_in` high 5 cycles, low 7, high → one `done` pulse; `width` = 5, `period` = 12, `overflow` = 0, `busy` back to 0.
- `edge_sel` = 1; arm, then drive `trig_in` low 3 cycles, high 9, low → `width` = 3, `period` = 12.
- `trig_in` held high before arm; arm, then low 4 cycles, high 6, low 4, high → the first high is ignored; `width` = 6, `period` = 10.
- CNT_WIDTH = 8; arm, then `trig_in` high for 300 cycles → `done` after cnt reaches 255; `overflow` = 1, `width` = 255, `period` = 255.
- Pulse `arm` repeatedly during HIGH → no restart; results are identical to the single-arm run.
- Assert `rst_n` = 0 while in LOW → all outputs are 0 immediately (asynchronously), no `done` pulse; after release the block sits in IDLE.

Source files
------------

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// Module      : trigger_capture
// Description : Measures an asynchronous trigger pulse train after an arm
//               request. It reports the active-phase width and the
//               leading-to-leading period in clk cycles, then issues a
//               one-cycle done strobe. Results hold until the next arm.
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_capture #(
  parameter int CNT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trig_in,
  input  logic                 arm,
  input  logic                 edge_sel,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] width,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 overflow
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LEAD = 3'd1,
    S_HIGH      = 3'd2,
    S_LOW       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_s1;
  logic                 r_s2;
  logic                 r_s3;
  logic                 r_edge_sel;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_act;
  logic                 w_prev;
  logic                 w_lead;
  logic                 w_trail;
  logic                 w_cnt_max;
  logic [CNT_WIDTH-1:0] w_cnt_inc;

  // Two-flop synchronizer for the asynchronous trigger, plus a delay stage
  // so edges can be detected on the synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= trig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Polarity is normalised with the edge select latched at arm, so an
  // active-low pulse train looks exactly like an active-high one.
  assign w_act     = r_s2 ^ r_edge_sel;
  assign w_prev    = r_s3 ^ r_edge_sel;
  assign w_lead    = w_act & ~w_prev;
  assign w_trail   = ~w_act & w_prev;
  assign w_cnt_max = (r_cnt == C_CNT_MAX);
  assign w_cnt_inc = w_cnt_max ? r_cnt : (r_cnt + C_CNT_ONE);

  // Measurement FSM with saturating counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_edge_sel <= 1'b0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      width      <= '0;
      period     <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_edge_sel <= edge_sel;
            width      <= '0;
            period     <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            r_state    <= S_WAIT_LEAD;
          end
        end
        S_WAIT_LEAD: begin
          // A level already active at arm produces no leading edge here,
          // so a fresh edge is always required.
          if (w_lead) begin
            r_cnt   <= C_CNT_ONE;
            r_state <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (w_trail) begin
            width   <= r_cnt;
            r_cnt   <= w_cnt_inc;
            r_state <= S_LOW;
          end else if (w_cnt_max) begin
            overflow <= 1'b1;
            width    <= C_CNT_MAX;
            period   <= C_CNT_MAX;
            done     <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_LOW: begin
          // A leading edge arriving together with saturation still counts
          // as a valid measurement.
          if (w_lead) begin
            period  <= r_cnt;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else if (w_cnt_max) begin
            overflow <= 1'b1;
            period   <= C_CNT_MAX;
            done     <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_trigger_capture
// Description : Directed self-checking bench for trigger_capture, using a
//               24-bit instance and an 8-bit instance for saturation cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_capture;

  localparam int W  = 24;
  localparam int W8 = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig_in = 1'b0;
  logic          arm = 1'b0;
  logic          edge_sel = 1'b0;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [W-1:0]  width;
  logic [W-1:0]  period;

  logic          trig8 = 1'b0;
  logic          arm8 = 1'b0;
  logic          busy8;
  logic          done8;
  logic          overflow8;
  logic [W8-1:0] width8;
  logic [W8-1:0] period8;

  int n_tests = 0;
  int n_fail = 0;
  int done_count = 0;
  int done8_count = 0;

  always #5 clk = ~clk;

  trigger_capture #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .arm(arm), .edge_sel(edge_sel),
    .busy(busy), .done(done), .width(width), .period(period), .overflow(overflow)
  );

  trigger_capture #(.CNT_WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .trig_in(trig8), .arm(arm8), .edge_sel(1'b0),
    .busy(busy8), .done(done8), .width(width8), .period(period8), .overflow(overflow8)
  );

  // Count done pulses of both instances.
  always @(negedge clk) begin
    if (done)  done_count++;
    if (done8) done8_count++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic sel);
    edge_sel = sel;
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done8(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done8) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    n_tests++;
    if ({busy, done, overflow, width, period} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b width=%0d period=%0d, want all 0",
               busy, done, overflow, width, period);
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_basic_high();
    bit got;
    int base;
    base = done_count;
    do_arm(1'b0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_busy_after_arm: got %b, want 1", busy);
    end
    trig_in = 1'b1; step(5);
    trig_in = 1'b0; step(7);
    trig_in = 1'b1;
    wait_done(10, got);
    n_tests++;
    if (got !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_done: no done within budget");
    end
    n_tests++;
    if (width !== 24'd5 || period !== 24'd12 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_results: got width=%0d period=%0d ovf=%b, want 5 12 0", width, period, overflow);
    end
    step(2);
    n_tests++;
    if (busy !== 1'b0 || done_count !== base + 1) begin
      n_fail++;
      $display("FAIL t1_after_done: got busy=%b pulses=%0d, want busy=0 pulses=1", busy, done_count - base);
    end
    trig_in = 1'b0;
    step(5);
    n_tests++;
    if (width !== 24'd5 || period !== 24'd12) begin
      n_fail++;
      $display("FAIL t1_hold: got width=%0d period=%0d, want 5 12", width, period);
    end
  endtask

  task automatic test_active_low();
    bit got;
    trig_in = 1'b1;
    step(4);
    do_arm(1'b1);
    edge_sel = 1'b0;
    n_tests++;
    if (width !== '0 || period !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t2_arm_clear: got width=%0d period=%0d busy=%b, want 0 0 1", width, period, busy);
    end
    trig_in = 1'b0; step(3);
    trig_in = 1'b1; step(9);
    trig_in = 1'b0;
    wait_done(10, got);
    n_tests++;
    if (got !== 1'b1 || width !== 24'd3 || period !== 24'd12 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_results: got done=%b width=%0d period=%0d ovf=%b, want 1 3 12 0",
               got, width, period, overflow);
    end
    step(3);
  endtask

  task automatic test_pre_active();
    bit got;
    int base;
    trig_in = 1'b1;
    step(4);
    base = done_count;
    do_arm(1'b0);
    step(3);
    n_tests++;
    if (busy !== 1'b1 || done_count !== base) begin
      n_fail++;
      $display("FAIL t3_waiting: got busy=%b pulses=%0d, want busy=1 pulses=0", busy, done_count - base);
    end
    trig_in = 1'b0; step(4);
    trig_in = 1'b1; step(6);
    trig_in = 1'b0; step(4);
    trig_in = 1'b1;
    wait_done(10, got);
    n_tests++;
    if (got !== 1'b1 || width !== 24'd6 || period !== 24'd10) begin
      n_fail++;
      $display("FAIL t3_results: got done=%b width=%0d period=%0d, want 1 6 10", got, width, period);
    end
    trig_in = 1'b0;
    step(3);
  endtask

  task automatic test_arm_during_high();
    bit got;
    int base;
    base = done_count;
    do_arm(1'b0);
    trig_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      arm = (i % 2 == 0);
      step(1);
    end
    trig_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      arm = (i % 2 == 1);
      step(1);
    end
    arm = 1'b0;
    trig_in = 1'b1;
    wait_done(10, got);
    n_tests++;
    if (got !== 1'b1 || width !== 24'd5 || period !== 24'd12 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_rearm: got done=%b width=%0d period=%0d ovf=%b, want 1 5 12 0",
               got, width, period, overflow);
    end
    step(2);
    n_tests++;
    if (done_count !== base + 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_pulses: got pulses=%0d busy=%b, want 1 0", done_count - base, busy);
    end
    trig_in = 1'b0;
    step(3);
  endtask

  task automatic test_overflow_high();
    bit got;
    arm8 = 1'b1; step(1); arm8 = 1'b0;
    trig8 = 1'b1;
    wait_done8(300, got);
    n_tests++;
    if (got !== 1'b1 || overflow8 !== 1'b1 || width8 !== 8'd255 || period8 !== 8'd255) begin
      n_fail++;
      $display("FAIL t4_ovf_high: got done=%b ovf=%b width=%0d period=%0d, want 1 1 255 255",
               got, overflow8, width8, period8);
    end
    step(1);
    trig8 = 1'b0;
    step(4);
  endtask

  task automatic test_lead_at_saturation();
    bit got;
    arm8 = 1'b1; step(1); arm8 = 1'b0;
    trig8 = 1'b1; step(5);
    trig8 = 1'b0; step(250);
    trig8 = 1'b1;
    wait_done8(10, got);
    n_tests++;
    if (got !== 1'b1 || overflow8 !== 1'b0 || width8 !== 8'd5 || period8 !== 8'd255) begin
      n_fail++;
      $display("FAIL t4_edge_wins: got done=%b ovf=%b width=%0d period=%0d, want 1 0 5 255",
               got, overflow8, width8, period8);
    end
    trig8 = 1'b0;
    step(4);
  endtask

  task automatic test_overflow_low();
    bit got;
    arm8 = 1'b1; step(1); arm8 = 1'b0;
    trig8 = 1'b1; step(5);
    trig8 = 1'b0; step(251);
    trig8 = 1'b1;
    wait_done8(10, got);
    n_tests++;
    if (got !== 1'b1 || overflow8 !== 1'b1 || width8 !== 8'd5 || period8 !== 8'd255) begin
      n_fail++;
      $display("FAIL t4_ovf_low: got done=%b ovf=%b width=%0d period=%0d, want 1 1 5 255",
               got, overflow8, width8, period8);
    end
    trig8 = 1'b0;
    step(4);
  endtask

  task automatic test_reset_in_low();
    int base;
    base = done_count;
    do_arm(1'b0);
    trig_in = 1'b1; step(5);
    trig_in = 1'b0; step(3);
    n_tests++;
    if (width !== 24'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_pre_reset: got width=%0d busy=%b, want 5 1", width, busy);
    end
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({busy, done, overflow, width, period} !== '0) begin
      n_fail++;
      $display("FAIL t6_async_reset: got busy=%b done=%b ovf=%b width=%0d period=%0d, want all 0",
               busy, done, overflow, width, period);
    end
    step(2);
    rst_n = 1'b1;
    trig_in = 1'b1;
    step(20);
    n_tests++;
    if (done_count !== base || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_after_release: got pulses=%0d busy=%b, want 0 0", done_count - base, busy);
    end
    trig_in = 1'b0;
    step(3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_high();
    test_active_low();
    test_pre_active();
    test_arm_during_high();
    test_overflow_high();
    test_lead_at_saturation();
    test_overflow_low();
    test_reset_in_low();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
